// File: rtl/i2c_pkg.sv
// Shared I2C constants and the target state encoding.
// The initiator side uses the same ACK/NACK and width constants.
package i2c_pkg;

   localparam int I2C_BYTE_W   = 8;
   localparam int I2C_ADDR_W   = 7;
   localparam int I2C_BITCNT_W = 4;

   localparam logic I2C_ACK  = 1'b0;
   localparam logic I2C_NACK = 1'b1;

   typedef enum logic [3:0] {
      ST_IDLE,
      ST_ADDR,
      ST_ADDR_ACK,
      ST_PTR,
      ST_PTR_ACK,
      ST_WR,
      ST_WR_ACK,
      ST_RD,
      ST_RD_ACK,
      ST_WAIT
   } i2c_state_e;

endpackage

// File: rtl/i2c_line_sync.sv
// Synchronizer for one raw bus line, with rise/fall strobes taken on the
// synchronized value. All flops reset to 1, which is the idle bus level.
module i2c_line_sync #(
   parameter int STAGES = 2
) (
   input  logic clk,
   input  logic rst_n,
   input  logic line_i,
   output logic level_o,
   output logic rise_o,
   output logic fall_o
);

   logic [STAGES-1:0] sync_q, sync_d;
   logic              prev_q, prev_d;

   always_comb begin
      sync_d = {sync_q[STAGES-2:0], line_i};
      prev_d = sync_q[STAGES-1];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q <= '1;
         prev_q <= 1'b1;
      end else begin
         sync_q <= sync_d;
         prev_q <= prev_d;
      end
   end

   assign level_o = sync_q[STAGES-1];
   assign rise_o  = sync_q[STAGES-1] & ~prev_q;
   assign fall_o  = ~sync_q[STAGES-1] & prev_q;

endmodule

// File: rtl/i2c_target.sv
// I2C target exposing an 8-bit register space: pointer write, register writes
// with auto-increment, and sequential reads. Open-drain SDA only; no stretching.
module i2c_target
   import i2c_pkg::*;
#(
   parameter logic [I2C_ADDR_W-1:0] ADDR        = 7'h42,
   parameter int                    SYNC_STAGES = 2
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  scl_in,
   input  logic                  sda_in,
   output logic                  sda_oe,
   output logic [I2C_BYTE_W-1:0] reg_addr,
   output logic [I2C_BYTE_W-1:0] reg_wdata,
   output logic                  reg_we,
   input  logic [I2C_BYTE_W-1:0] reg_rdata,
   output logic                  busy
);

   logic scl_s, scl_rise, scl_fall;
   logic sda_s, sda_rise, sda_fall;

   i2c_line_sync #(.STAGES(SYNC_STAGES)) u_scl_sync (
      .clk(clk), .rst_n(rst_n), .line_i(scl_in),
      .level_o(scl_s), .rise_o(scl_rise), .fall_o(scl_fall)
   );

   i2c_line_sync #(.STAGES(SYNC_STAGES)) u_sda_sync (
      .clk(clk), .rst_n(rst_n), .line_i(sda_in),
      .level_o(sda_s), .rise_o(sda_rise), .fall_o(sda_fall)
   );

   i2c_state_e              state_q, state_d;
   logic [I2C_BITCNT_W-1:0] cnt_q, cnt_d;
   logic [I2C_BYTE_W-1:0]   shift_q, shift_d;
   logic [I2C_BYTE_W-1:0]   ptr_q, ptr_d;
   logic [I2C_BYTE_W-1:0]   wdata_q, wdata_d;
   logic                    we_q, we_d;
   logic                    sda_oe_q, sda_oe_d;
   logic                    busy_q, busy_d;
   logic                    rw_q, rw_d;

   logic                  start_det, stop_det;
   logic [I2C_BYTE_W-1:0] rx_byte;

   assign start_det = scl_s & sda_fall;
   assign stop_det  = scl_s & sda_rise;
   assign rx_byte   = {shift_q[I2C_BYTE_W-2:0], sda_s};

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      shift_d  = shift_q;
      ptr_d    = ptr_q;
      wdata_d  = wdata_q;
      we_d     = 1'b0;
      sda_oe_d = sda_oe_q;
      busy_d   = busy_q;
      rw_d     = rw_q;
      if (stop_det) begin
         state_d  = ST_IDLE;
         sda_oe_d = 1'b0;
         busy_d   = 1'b0;
      end else if (start_det) begin
         state_d  = ST_ADDR;
         cnt_d    = '0;
         sda_oe_d = 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: ;
            ST_WAIT: begin
               sda_oe_d = 1'b0;
               busy_d   = 1'b0;
            end
            ST_ADDR, ST_PTR, ST_WR: begin
               if (scl_rise) begin
                  shift_d = rx_byte;
                  cnt_d   = cnt_q + 4'd1;
                  if (cnt_q == 4'd7) begin
                     if (state_q == ST_ADDR) begin
                        if (rx_byte[7:1] == ADDR) begin
                           state_d = ST_ADDR_ACK;
                           rw_d    = rx_byte[0];
                           busy_d  = 1'b1;
                        end else begin
                           state_d = ST_WAIT;
                           busy_d  = 1'b0;
                        end
                     end else if (state_q == ST_PTR) begin
                        ptr_d   = rx_byte;
                        state_d = ST_PTR_ACK;
                     end else begin
                        wdata_d = rx_byte;
                        we_d    = 1'b1;
                        state_d = ST_WR_ACK;
                     end
                  end
               end
            end
            // First SCL fall after bit 8 asserts ACK; the next fall ends bit 9.
            ST_ADDR_ACK, ST_PTR_ACK, ST_WR_ACK: begin
               if (scl_fall) begin
                  if (!sda_oe_q) begin
                     sda_oe_d = 1'b1;
                  end else begin
                     sda_oe_d = 1'b0;
                     cnt_d    = '0;
                     if (state_q == ST_ADDR_ACK) begin
                        if (rw_q) begin
                           state_d  = ST_RD;
                           shift_d  = reg_rdata;
                           sda_oe_d = ~reg_rdata[7];
                        end else begin
                           state_d = ST_PTR;
                        end
                     end else begin
                        state_d = ST_WR;
                        if (state_q == ST_WR_ACK) ptr_d = ptr_q + 8'd1;
                     end
                  end
               end
            end
            ST_RD: begin
               if (scl_rise) begin
                  cnt_d = cnt_q + 4'd1;
               end else if (scl_fall) begin
                  if (cnt_q == 4'd8) begin
                     sda_oe_d = 1'b0;
                     state_d  = ST_RD_ACK;
                  end else begin
                     shift_d  = {shift_q[I2C_BYTE_W-2:0], 1'b0};
                     sda_oe_d = ~shift_q[6];
                  end
               end
            end
            // Pointer advances at the ACK sample so reg_rdata settles before the reload.
            ST_RD_ACK: begin
               if (scl_rise) begin
                  cnt_d = cnt_q + 4'd1;
                  if (sda_s == I2C_NACK) begin
                     state_d = ST_WAIT;
                     busy_d  = 1'b0;
                  end else begin
                     ptr_d = ptr_q + 8'd1;
                  end
               end else if (scl_fall && cnt_q == 4'd9) begin
                  state_d  = ST_RD;
                  cnt_d    = '0;
                  shift_d  = reg_rdata;
                  sda_oe_d = ~reg_rdata[7];
               end
            end
            default: state_d = ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= ST_IDLE;
         cnt_q    <= '0;
         shift_q  <= '0;
         ptr_q    <= '0;
         wdata_q  <= '0;
         we_q     <= 1'b0;
         sda_oe_q <= 1'b0;
         busy_q   <= 1'b0;
         rw_q     <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         shift_q  <= shift_d;
         ptr_q    <= ptr_d;
         wdata_q  <= wdata_d;
         we_q     <= we_d;
         sda_oe_q <= sda_oe_d;
         busy_q   <= busy_d;
         rw_q     <= rw_d;
      end
   end

   assign sda_oe    = sda_oe_q;
   assign reg_addr  = ptr_q;
   assign reg_wdata = wdata_q;
   assign reg_we    = we_q;
   assign busy      = busy_q;

endmodule

// File: tb/tb_i2c_target.sv
// Bench for i2c_target: bus-initiator tasks drive SCL/SDA, expected register
// writes and read bytes go into queues that monitors pop and compare.
module tb_i2c_target;

   localparam int Q = 10;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       scl_drv = 1'b1;
   logic       sda_drv = 1'b1;
   logic       scl_in, sda_in;
   logic       sda_oe, reg_we, busy;
   logic [7:0] reg_addr, reg_wdata, reg_rdata;
   logic [7:0] regs [256];

   logic [15:0] exp_wr_q[$];
   logic [7:0]  exp_rd_q[$];
   logic [15:0] wr_exp;
   logic [7:0]  rd_exp;
   logic [7:0]  rd_byte;
   event        rd_ev;
   int          n_vec = 0;
   int          n_err = 0;
   int          oe_cnt = 0;
   int          oe_mark;

   assign scl_in    = scl_drv;
   assign sda_in    = sda_drv & ~sda_oe;
   assign reg_rdata = regs[reg_addr];

   always #10 clk = ~clk;

   i2c_target #(.ADDR(7'h42), .SYNC_STAGES(2)) dut (
      .clk(clk), .rst_n(rst_n), .scl_in(scl_in), .sda_in(sda_in),
      .sda_oe(sda_oe), .reg_addr(reg_addr), .reg_wdata(reg_wdata),
      .reg_we(reg_we), .reg_rdata(reg_rdata), .busy(busy)
   );

   task automatic check(input string nm, input logic [15:0] act, input logic [15:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, required %h", nm, act, exp);
      end
   endtask

   // Write monitor: every reg_we must match the next queued (addr, data).
   always @(negedge clk) begin
      if (rst_n && reg_we) begin
         if (exp_wr_q.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL unexpected_we: got addr %h data %h, required no write", reg_addr, reg_wdata);
         end else begin
            wr_exp = exp_wr_q.pop_front();
            check("reg_write", {reg_addr, reg_wdata}, wr_exp);
         end
      end
      if (sda_oe) oe_cnt++;
   end

   // Read monitor: bytes assembled by the initiator against queued register values.
   always @(rd_ev) begin
      if (exp_rd_q.size() == 0) begin
         n_vec++;
         n_err++;
         $display("FAIL unexpected_read: got %h, required no read", rd_byte);
      end else begin
         rd_exp = exp_rd_q.pop_front();
         check("read_byte", {8'h00, rd_byte}, {8'h00, rd_exp});
      end
   end

   task automatic dly();
      repeat (Q) @(negedge clk);
   endtask

   task automatic bus_start();
      sda_drv = 1'b1; dly();
      scl_drv = 1'b1; dly();
      sda_drv = 1'b0; dly();
      scl_drv = 1'b0; dly();
   endtask

   task automatic bus_stop();
      sda_drv = 1'b0; dly();
      scl_drv = 1'b1; dly();
      sda_drv = 1'b1; dly();
   endtask

   task automatic send_bit(input logic b);
      sda_drv = b; dly();
      scl_drv = 1'b1; dly(); dly();
      scl_drv = 1'b0; dly();
   endtask

   task automatic recv_bit(output logic b);
      sda_drv = 1'b1; dly();
      scl_drv = 1'b1; dly();
      b = sda_in; dly();
      scl_drv = 1'b0; dly();
   endtask

   task automatic write_byte(input logic [7:0] d, input logic exp_ack, input string nm);
      logic a;
      for (int i = 7; i >= 0; i--) send_bit(d[i]);
      recv_bit(a);
      check(nm, {15'd0, a}, {15'd0, exp_ack});
   endtask

   task automatic read_byte(input logic m_ack);
      logic [7:0] b;
      for (int i = 7; i >= 0; i--) recv_bit(b[i]);
      rd_byte = b;
      ->rd_ev;
      send_bit(m_ack);
   endtask

   initial begin
      repeat (200000) @(posedge clk);
      $display("FAIL watchdog: got no completion, required finish within 200000 clk");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [7:0] a;
      for (int i = 0; i < 256; i++) regs[i] = 8'h00;
      regs[8'h20] = 8'h11;
      regs[8'h21] = 8'h22;
      regs[8'h22] = 8'h33;
      regs[8'h30] = 8'hC7;
      repeat (5) @(negedge clk);
      rst_n = 1'b1;
      repeat (5) @(negedge clk);

      check("rst_sda_oe", {15'd0, sda_oe}, 16'd0);
      check("rst_reg_addr", {8'd0, reg_addr}, 16'h0000);
      check("rst_reg_wdata", {8'd0, reg_wdata}, 16'h0000);
      check("rst_reg_we", {15'd0, reg_we}, 16'd0);
      check("rst_busy", {15'd0, busy}, 16'd0);

      // Pointer 0x10, then two data bytes.
      exp_wr_q.push_back(16'h10A5);
      exp_wr_q.push_back(16'h113C);
      bus_start();
      write_byte(8'h84, 1'b0, "t1_addr_ack");
      check("t1_busy", {15'd0, busy}, 16'd1);
      write_byte(8'h10, 1'b0, "t1_ptr_ack");
      write_byte(8'hA5, 1'b0, "t1_d0_ack");
      write_byte(8'h3C, 1'b0, "t1_d1_ack");
      bus_stop();
      dly();
      check("t1_busy_after_stop", {15'd0, busy}, 16'd0);

      // Pointer wrap 0xFF -> 0x00.
      exp_wr_q.push_back(16'hFF01);
      exp_wr_q.push_back(16'h0002);
      bus_start();
      write_byte(8'h84, 1'b0, "wrap_addr_ack");
      write_byte(8'hFF, 1'b0, "wrap_ptr_ack");
      write_byte(8'h01, 1'b0, "wrap_d0_ack");
      write_byte(8'h02, 1'b0, "wrap_d1_ack");
      bus_stop();

      // Pointer 0x20, repeated START, three reads ending with NACK.
      bus_start();
      write_byte(8'h84, 1'b0, "rd_addr_ack");
      write_byte(8'h20, 1'b0, "rd_ptr_ack");
      bus_start();
      write_byte(8'h85, 1'b0, "rd_addr_r_ack");
      exp_rd_q.push_back(8'h11);
      exp_rd_q.push_back(8'h22);
      exp_rd_q.push_back(8'h33);
      read_byte(1'b0);
      read_byte(1'b0);
      read_byte(1'b1);
      check("rd_nack_sda_oe", {15'd0, sda_oe}, 16'd0);
      check("rd_nack_busy", {15'd0, busy}, 16'd0);
      check("rd_final_ptr", {8'd0, reg_addr}, 16'h0022);
      bus_stop();

      // Wrong address 0x43: no ACK, no drive, no write.
      oe_mark = oe_cnt;
      bus_start();
      write_byte(8'h86, 1'b1, "bad_addr_nack");
      write_byte(8'h55, 1'b1, "bad_data_nack");
      check("bad_busy", {15'd0, busy}, 16'd0);
      bus_stop();
      check("bad_no_oe", 16'(oe_cnt - oe_mark), 16'd0);

      // START in the 4th bit of a write data byte, then read.
      bus_start();
      write_byte(8'h84, 1'b0, "ab_addr_ack");
      write_byte(8'h30, 1'b0, "ab_ptr_ack");
      send_bit(1'b1);
      send_bit(1'b0);
      send_bit(1'b1);
      sda_drv = 1'b1; dly();
      scl_drv = 1'b1; dly();
      sda_drv = 1'b0; dly();
      scl_drv = 1'b0; dly();
      write_byte(8'h85, 1'b0, "ab_addr_r_ack");
      exp_rd_q.push_back(8'hC7);
      read_byte(1'b1);
      check("ab_busy", {15'd0, busy}, 16'd0);
      bus_stop();

      // Reset while the target is driving the address ACK.
      bus_start();
      a = 8'h84;
      for (int i = 7; i >= 0; i--) send_bit(a[i]);
      sda_drv = 1'b1; dly();
      check("rs_ack_driven", {15'd0, sda_oe}, 16'd1);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("rs_sda_released", {15'd0, sda_oe}, 16'd0);
      check("rs_reg_addr", {8'd0, reg_addr}, 16'h0000);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      scl_drv = 1'b1; dly(); dly();
      scl_drv = 1'b0; dly();
      check("rs_ignore_bus", {15'd0, sda_oe}, 16'd0);
      bus_stop();
      exp_wr_q.push_back(16'h5077);
      bus_start();
      write_byte(8'h84, 1'b0, "rs2_addr_ack");
      write_byte(8'h50, 1'b0, "rs2_ptr_ack");
      write_byte(8'h77, 1'b0, "rs2_d0_ack");
      bus_stop();
      dly();

      check("wr_queue_drained", 16'(exp_wr_q.size()), 16'd0);
      check("rd_queue_drained", 16'(exp_rd_q.size()), 16'd0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/i2c_target.md
# i2c_target

I2C target (responder) that exposes an 8-bit-addressed register space on an I2C bus. It is the responder counterpart to the `I2C_Driver` initiators already on the Mojo. Its first uses are bench loopback of the altimeter and IMU driver paths, and letting the ground link or a second board read sensor registers. Bus lines come in raw from the pads. The block only ever pulls SDA low (open-drain); it never drives SCL and never stretches the clock.

## Interface
Parameters:
- `ADDR`, 7'h42, 7-bit target address this block answers to.
- `SYNC_STAGES`, 2, synchronizer flops on SCL and SDA (minimum 2).

Ports:
- `clk`  in  1  system clock, 50 MHz; must be ≥ 16× SCL.
- `rst_n`  in  1  reset; one clock; reset is asynchronous and active-low.
- `scl_in`  in  1  raw SCL from pad.
- `sda_in`  in  1  raw SDA from pad.
- `sda_oe`  out  1  1 = pull SDA low; the top level ties the pad as `sda_oe ? 1'b0 : 1'bz`.
- `reg_addr`  out  8  register pointer.
- `reg_wdata`  out  8  write data, valid while `reg_we` is high.
- `reg_we`  out  1  one-cycle write strobe.
- `reg_rdata`  in  8  read data for `reg_addr`; must be valid within 1 clk of any `reg_addr` change.
- `busy`  out  1  high from an address-matched START until STOP or NACK-abort.

## Operation
- SCL and SDA each pass through `SYNC_STAGES` flops, reset value 1. Edge detection runs on the synchronized values.
- START: SDA falls while SCL is high. STOP: SDA rises while SCL is high. Both are detected in every state, including mid-byte.
- State machine: IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WR, WR_ACK, RD, RD_ACK, WAIT.
  - START from any state goes to ADDR and clears the bit counter.
  - STOP from any state goes to IDLE, with `sda_oe`=0 and `busy`=0.
  - ADDR shifts 8 bits MSB-first on SCL rising edges.
    - Match on bits [7:1] with R/W=0 goes to ADDR_ACK, then PTR.
    - Match with R/W=1 goes to ADDR_ACK, then RD.
    - Mismatch goes to WAIT with SDA untouched (NACK). General call 0x00 is not supported.
  - PTR: the 8th bit loads `reg_addr`, then PTR_ACK, then WR.
  - WR: the 8th bit sets `reg_wdata` and pulses `reg_we` (with `reg_addr` = pointer), then WR_ACK.
    - The pointer increments on the SCL falling edge that ends WR_ACK.
  - RD: the shift register loads `reg_rdata` on the SCL falling edge that ends ADDR_ACK or RD_ACK. Bits drive MSB-first as `sda_oe` = ~bit.
    - RD_ACK releases SDA and samples the initiator's bit on SCL rise.
    - ACK (0): pointer increments, then back to RD.
    - NACK (1): go to WAIT.
  - WAIT: `sda_oe`=0; only START or STOP leaves this state.
- The pointer is 8-bit and wraps 0xFF→0x00 in both directions of traffic. The pointer persists across transactions, so a pointer write followed by a repeated START and a read gives a standard register read.
- ACK: `sda_oe`=1 from the SCL falling edge after bit 8 to the SCL falling edge after bit 9.

## Timing
- Reset values: `sda_oe`=0, `reg_addr`=0x00, `reg_wdata`=0x00, `reg_we`=0, `busy`=0, state IDLE.
- Pad-to-detect latency is `SYNC_STAGES`+1 clk. `sda_oe` changes 1 clk after the synchronized SCL falling edge is detected, which is well inside SCL-low time.
- `reg_we` is high for exactly 1 clk, on the cycle the 8th WR bit is sampled.
- `busy` rises 1 clk after the address-match sample. It falls 1 clk after STOP detect, or on entry to WAIT.
- The block's own SDA transitions occur only while SCL is low, so they never create false START or STOP events.
- `rst_n` asserted mid-transfer releases SDA immediately (asynchronously). After reset the block ignores the bus until the next START.

## Structure
- Shared package `i2c_pkg`: state enum, `I2C_ACK`=1'b0, `I2C_NACK`=1'b1, and byte-width constants. `I2C_Driver` uses the same package for its constants.
- Sub-module `i2c_line_sync`: parameterised synchronizer plus rise/fall strobes for one line, instantiated twice.

## Test plan
- Write 0x10 to pointer, then bytes 0xA5 and 0x3C, then STOP → `reg_we` pulses twice, at (0x10, 0xA5) and (0x11, 0x3C); target ACKs all four bytes.
- Pointer 0x20, repeated START, read 3 bytes with ACK, ACK, NACK → bus reads regs 0x20–0x22; after the NACK `sda_oe`=0 and `busy`=0.
- Address 0x43 (wrong) → no ACK (SDA high on 9th clock), no `reg_we`, `sda_oe` stays 0 until STOP.
- Pointer 0xFF, write 0x01 and 0x02 → writes land at 0xFF and 0x00 (wrap).
- START during the 4th data bit of a write, then address 0x42/R → no `reg_we` for the aborted byte; read returns `reg_rdata` for the current pointer.
- `rst_n` low while the target is driving an ACK → `sda_oe`=0 within the same cycle; the following valid transaction completes normally.
